// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. It issues sequential word fetches to a
// synchronous-read instruction memory, collects the responses in a small
// instruction queue, and presents the queue head to decode.
//
// Parameters
//   DEPTH     instruction-queue entries (power of two, 2..16)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk          sole clock, all state on the rising edge
//   reset        asynchronous, active-low reset
//   imem_addr    instruction-memory byte address (always word aligned)
//   imem_req     a fetch is issued this cycle
//   imem_rdata   instruction data, valid the cycle after the matching imem_req
//   redirect     branch/jump taken: flush the queue and refetch
//   redirect_pc  new fetch address (low two bits ignored)
//   out_valid    out_instr/out_pc valid toward decode
//   out_ready    decode accepts this cycle
//   out_instr    head-of-queue instruction (0 while the queue is empty)
//   out_pc       address of out_instr (0 while the queue is empty)
//   occupancy    number of queued entries
//   perf_stall   cycles with out_ready && !out_valid (saturating)
//   perf_flush   redirect cycles (saturating)
//   state_dbg    control state: 0 = IDLE, 1 = RUN, 2 = FLUSH
//
// Build option
//   FETCH_PERF_EN  when defined, perf_stall/perf_flush are live saturating
//                  counters; otherwise both ports are tied to zero.
//
// Decode handshake: an entry moves to decode on a cycle where out_valid and
// out_ready are both high. out_valid never depends on out_ready, and while
// out_valid is high without out_ready, out_instr/out_pc hold their value.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_addr,
    output logic                     imem_req,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              perf_stall,
    output logic [31:0]              perf_flush,
    output logic [1:0]               state_dbg
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_P = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    state_e        state_q;

    // Fetch address kept as a word index, so the byte address is aligned by
    // construction and the +4 wrap from FFFF_FFFC to 0 is a natural overflow.
    logic [29:0]   fetch_pc_q;

    // At most one request is outstanding; its word address tags the response.
    logic          inflight_q;
    logic [29:0]   inflight_pc_q;

    // Circular instruction queue.
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] occ_q;
    logic [31:0]   instr_mem [DEPTH];
    logic [29:0]   pc_mem    [DEPTH];

    logic [CW:0]   pending;
    logic          queue_full;
    logic          push;
    logic          pop;

    // Only the word part of the redirect target is used.
    logic          unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // ------------------------------------------------------------------
    // Issue / queue control
    // ------------------------------------------------------------------
    // Queued entries plus the outstanding response must fit in the queue,
    // otherwise the response could arrive with nowhere to go.
    assign pending    = {1'b0, occ_q} + {{CW{1'b0}}, inflight_q};
    assign queue_full = (occ_q == DEPTH_C);

    // A redirect suppresses issue: the next fetch starts from the new target.
    // Gating with reset keeps the request low while reset is held.
    assign imem_req   = reset && !redirect && (pending < DEPTH_P);
    assign imem_addr  = {fetch_pc_q, 2'b00};

    assign out_valid  = (occ_q != '0);

    // A handshake in a redirect cycle is accepted by decode but the queue is
    // emptied anyway, so it needs no pointer update of its own.
    assign pop        = out_valid && out_ready && !redirect;

    // The response from a flushed request never reaches the queue. The
    // full-queue term only matters for a push that coincides with a pop.
    assign push       = inflight_q && (state_q != S_FLUSH) && !redirect &&
                        (!queue_full || pop);

    // No bypass: decode only ever sees registered queue contents.
    assign out_instr  = out_valid ? instr_mem[head_q] : 32'd0;
    assign out_pc     = out_valid ? {pc_mem[head_q], 2'b00} : 32'd0;
    assign occupancy  = occ_q;
    assign state_dbg  = state_q;

    // ------------------------------------------------------------------
    // Control state machine
    // IDLE while reset is held, RUN in normal operation, FLUSH for the
    // single cycle after a redirect (re-entered on back-to-back redirects).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_q <= redirect ? S_FLUSH : S_RUN;
                S_RUN:   state_q <= redirect ? S_FLUSH : S_RUN;
                S_FLUSH: state_q <= redirect ? S_FLUSH : S_RUN;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fetch pointer, in-flight tracking and queue pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC[31:2];
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            occ_q         <= '0;
        end else if (redirect) begin
            // Redirect wins over issue, push and pop in the same cycle.
            fetch_pc_q    <= redirect_pc[31:2];
            inflight_q    <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            occ_q         <= '0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                fetch_pc_q    <= fetch_pc_q + 30'd1;
                inflight_pc_q <= fetch_pc_q;
            end
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + CW'(1);
                2'b01:   occ_q <= occ_q - CW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only visible once pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= imem_rdata;
            pc_mem[tail_q]    <= inflight_pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (out_ready && !out_valid && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (redirect && (perf_flush_q != 32'hFFFF_FFFF)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`else
    assign perf_stall = 32'd0;
    assign perf_flush = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. A queue-level model of the fetch pipeline (fetch
// pointer, one outstanding request, FIFO of fetched addresses) predicts every
// output on every falling edge; directed scenarios pin the model with
// hand-computed literals, then a randomized phase exercises backpressure,
// redirects and reset pulses. A second instance with RESET_PC = FFFF_FFF8
// covers the address wrap.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int DEPTH = 4;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 0)
    logic [31:0]            imem_addr;
    logic                   imem_req;
    logic [31:0]            imem_rdata = 32'hDEAD_BEEF;
    logic                   redirect = 1'b0;
    logic [31:0]            redirect_pc = 32'd0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [31:0]            out_instr;
    logic [31:0]            out_pc;
    logic [$clog2(DEPTH):0] occupancy;
    logic [31:0]            perf_stall;
    logic [31:0]            perf_flush;
    logic [1:0]             state_dbg;

    // Wrap instance (RESET_PC = FFFF_FFF8), free-running with out_ready = 1
    logic [31:0]            imem_addr_w;
    logic                   imem_req_w;
    logic [31:0]            imem_rdata_w = 32'hDEAD_BEEF;
    logic                   redirect_w = 1'b0;
    logic [31:0]            redirect_pc_w = 32'd0;
    logic                   out_valid_w;
    logic                   out_ready_w = 1'b1;
    logic [31:0]            out_instr_w;
    logic [31:0]            out_pc_w;
    logic [$clog2(DEPTH):0] occupancy_w;
    logic [31:0]            perf_stall_w;
    logic [31:0]            perf_flush_w;
    logic [1:0]             state_dbg_w;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .occupancy   (occupancy),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush),
        .state_dbg   (state_dbg)
    );

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr_w),
        .imem_req    (imem_req_w),
        .imem_rdata  (imem_rdata_w),
        .redirect    (redirect_w),
        .redirect_pc (redirect_pc_w),
        .out_valid   (out_valid_w),
        .out_ready   (out_ready_w),
        .out_instr   (out_instr_w),
        .out_pc      (out_pc_w),
        .occupancy   (occupancy_w),
        .perf_stall  (perf_stall_w),
        .perf_flush  (perf_flush_w),
        .state_dbg   (state_dbg_w)
    );

    // ------------------------------------------------------------------
    // Comparison bookkeeping
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_0F0F;
    endfunction

    // ------------------------------------------------------------------
    // Instruction memories: synchronous read, data valid the cycle after
    // the request; garbage otherwise so stray pushes show up.
    // ------------------------------------------------------------------
    logic        mem_fire, mem_fire_w;
    logic [31:0] mem_addr, mem_addr_w;

    initial begin
        forever begin
            @(negedge clk);
            mem_fire = imem_req;
            mem_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_rdata = mem_fire ? instr_of(mem_addr) : 32'hDEAD_BEEF;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            mem_fire_w = imem_req_w;
            mem_addr_w = imem_addr_w;
            @(posedge clk);
            #1;
            imem_rdata_w = mem_fire_w ? instr_of(mem_addr_w) : 32'hDEAD_BEEF;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: behavioural model of the fetch pipeline
    //   exp_q   : addresses fetched and waiting for decode, oldest first
    //   m_pc    : next address to fetch
    //   m_inf   : a request was issued last cycle (response arrives now)
    // ------------------------------------------------------------------
    logic [31:0] exp_q[$];
    logic [31:0] m_pc       = 32'd0;
    bit          m_inf      = 1'b0;
    logic [31:0] m_inf_addr = 32'd0;
    logic [31:0] m_stall    = 32'd0;
    logic [31:0] m_flush    = 32'd0;
    logic [1:0]  m_state    = 2'd0;
    bit          m_req;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            m_pc    = 32'd0;
            m_inf   = 1'b0;
            m_stall = 32'd0;
            m_flush = 32'd0;
            m_state = 2'd0;
            chk("rst_imem_req",  32'(imem_req),  32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_occupancy", 32'(occupancy), 32'd0);
            chk("rst_out_pc",    out_pc,         32'd0);
            chk("rst_out_instr", out_instr,      32'd0);
            chk("rst_imem_addr", imem_addr,      32'd0);
            chk("rst_state",     32'(state_dbg), 32'd0);
            chk("rst_perf_stall", perf_stall,    32'd0);
            chk("rst_perf_flush", perf_flush,    32'd0);
        end else begin
            m_req = !redirect && ((exp_q.size() + int'(m_inf)) < DEPTH);
            chk("imem_req",  32'(imem_req),  32'(m_req));
            chk("imem_addr", imem_addr,      m_pc);
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_pc",    out_pc,    exp_q[0]);
                chk("out_instr", out_instr, instr_of(exp_q[0]));
            end
            chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
            chk("state",     32'(state_dbg), 32'(m_state));
`ifdef FETCH_PERF_EN
            chk("perf_stall", perf_stall, m_stall);
            chk("perf_flush", perf_flush, m_flush);
`else
            chk("perf_stall_tied", perf_stall, 32'd0);
            chk("perf_flush_tied", perf_flush, 32'd0);
`endif
            // Advance the model across the coming rising edge.
            if (out_ready && (exp_q.size() == 0) && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
            if (redirect && (m_flush != 32'hFFFF_FFFF)) m_flush = m_flush + 32'd1;
            m_state = redirect ? 2'd2 : 2'd1;
            if (redirect) begin
                exp_q.delete();
                m_inf = 1'b0;
                m_pc  = {redirect_pc[31:2], 2'b00};
            end else begin
                if (out_ready && (exp_q.size() != 0)) void'(exp_q.pop_front());
                if (m_inf) exp_q.push_back(m_inf_addr);
                m_inf      = m_req;
                m_inf_addr = m_pc;
                if (m_req) m_pc = m_pc + 32'd4;
            end
        end
    end

    // First three addresses delivered by the wrap instance.
    logic [31:0] w_seen[$];
    always @(negedge clk) begin
        if (reset && out_valid_w && (w_seen.size() < 3)) w_seen.push_back(out_pc_w);
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int mode;
        mode = 2;

        // Streaming after reset release with decode always ready.
        tick(); tick(); tick();
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("a_c0_imem_addr", imem_addr, 32'h0000_0000);
        chk("a_c0_imem_req",  32'(imem_req), 32'd1);
        chk("a_c0_out_valid", 32'(out_valid), 32'd0);
        chk("a_c0_out_pc",    out_pc, 32'd0);
        chk("w_c0_imem_addr", imem_addr_w, 32'hFFFF_FFF8);
        tick();
        @(negedge clk);
        chk("a_c1_imem_addr", imem_addr, 32'h0000_0004);
        chk("a_c1_out_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("a_c2_out_valid", 32'(out_valid), 32'd1);
        chk("a_c2_out_pc",    out_pc, 32'h0000_0000);
        chk("a_c2_out_instr", out_instr, 32'h5A5A_0F0F);
        chk("a_c2_imem_addr", imem_addr, 32'h0000_0008);
        tick();
        @(negedge clk);
        chk("a_c3_out_pc", out_pc, 32'h0000_0004);
        tick();
        @(negedge clk);
        chk("a_c4_out_pc", out_pc, 32'h0000_0008);

        // Backpressure fills the queue, then drains in order without gaps.
        tick();
        do_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        repeat (9) tick();
        @(negedge clk);
        chk("b_full_occupancy", 32'(occupancy), 32'd4);
        chk("b_full_imem_req",  32'(imem_req), 32'd0);
        chk("b_full_out_valid", 32'(out_valid), 32'd1);
        chk("b_full_out_pc",    out_pc, 32'h0000_0000);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b_drain_valid", 32'(out_valid), 32'd1);
            chk("b_drain_pc",    out_pc, 32'(i * 4));
            tick();
        end

        // Redirect with three entries queued and one response in flight.
        do_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        repeat (4) tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("c_n_occupancy", 32'(occupancy), 32'd3);
        chk("c_n_imem_req",  32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("c_n1_occupancy", 32'(occupancy), 32'd0);
        chk("c_n1_imem_addr", imem_addr, 32'h0000_0100);
        chk("c_n1_imem_req",  32'(imem_req), 32'd1);
        chk("c_n1_state",     32'(state_dbg), 32'd2);
        tick();
        @(negedge clk);
        chk("c_n2_out_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("c_n3_out_valid", 32'(out_valid), 32'd1);
        chk("c_n3_out_pc",    out_pc, 32'h0000_0100);
        tick();
        @(negedge clk);
        chk("c_n4_out_pc", out_pc, 32'h0000_0104);

        // Back-to-back redirects: only the second target streams out.
        tick();
        do_reset();
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        chk("d_n_imem_req", 32'(imem_req), 32'd0);
        tick();
        redirect_pc = 32'h0000_0300;
        @(negedge clk);
        chk("d_n1_imem_req", 32'(imem_req), 32'd0);
        chk("d_n1_state",    32'(state_dbg), 32'd2);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("d_n2_imem_addr", imem_addr, 32'h0000_0300);
        chk("d_n2_state",     32'(state_dbg), 32'd2);
        tick();
        @(negedge clk);
        chk("d_n3_out_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("d_n4_out_pc", out_pc, 32'h0000_0300);
`ifdef FETCH_PERF_EN
        chk("d_perf_flush", perf_flush, 32'd2);
        chk("d_perf_stall", perf_stall, 32'd5);
`else
        chk("d_perf_flush_tied", perf_flush, 32'd0);
`endif
        tick();
        @(negedge clk);
        chk("d_n5_out_pc", out_pc, 32'h0000_0304);

        // Reset pulse with a full queue.
        tick();
        do_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("e_full_occupancy", 32'(occupancy), 32'd4);
        tick();
        reset = 1'b0;
        #1;
        chk("e_rst_out_valid", 32'(out_valid), 32'd0);
        chk("e_rst_occupancy", 32'(occupancy), 32'd0);
        chk("e_rst_imem_req",  32'(imem_req), 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("e_rel_imem_addr", imem_addr, 32'h0000_0000);
        chk("e_rel_imem_req",  32'(imem_req), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ((i % 64) == 0) mode = $urandom_range(0, 2);
            reset = ((i % 700) == 350) ? 1'b0 : 1'b1;
            case (mode)
                0:       out_ready = ($urandom_range(0, 99) < 20);
                1:       out_ready = ($urandom_range(0, 99) < 70);
                default: out_ready = 1'b1;
            endcase
            redirect = ($urandom_range(0, 99) < 5);
            redirect_pc = $urandom;
            if ($urandom_range(0, 9) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        end
        tick();
        reset = 1'b1;
        redirect = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();

        // Wrap instance: FFFF_FFF8, FFFF_FFFC, 0000_0000.
        chk("w_seen_count", 32'(w_seen.size()), 32'd3);
        if (w_seen.size() >= 3) begin
            chk("w_pc0", w_seen[0], 32'hFFFF_FFF8);
            chk("w_pc1", w_seen[1], 32'hFFFF_FFFC);
            chk("w_pc2", w_seen[2], 32'h0000_0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
